sprite_fetch_arbiter: RTL and testbench
=======================================

Name: sprite_fetch_arbiter

Overview:
- Shares one single-port sprite/texture ROM among three pixel-data requesters: MARIO (slot 0), BRICK (slot 1) and BACKGROUND (slot 2).
- Sits between the per-layer address generators and the shared ROM. Its per-slot RGB outputs feed the colour mapper's mario/brick/bg data inputs.
- Arbitration is round-robin with a registered grant. A tag pipeline routes each ROM return to the requesting slot.
- Each returned word is flagged when it equals the transparency key colour.

Parameters:
ADDR_W, 19, ROM address width
DATA_W, 24, ROM word width ({R,G,B}, 8 bits each)
ROM_LAT, 2, ROM read latency in cycles (legal 1..4)
KEY_COLOR, 24'hFE06FF, transparency key value

Ports:
Clk  in  1  system clock; all logic on rising edge
Reset  in  1  synchronous, active-low reset
line_start  in  1  one-cycle pulse at start of each scanline
req  in  3  per-slot request; held until acked
addr  in  3*ADDR_W  per-slot address; slot s at [s*ADDR_W +: ADDR_W]
ack  out  3  one-hot; one-cycle pulse = slot's request accepted
rom_rd  out  1  read strobe to shared ROM
rom_addr  out  ADDR_W  address to shared ROM
rom_q  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd
valid  out  3  one-cycle pulse: slot's rgb/key updated this cycle
rgb  out  3*DATA_W  per-slot last returned word; slot s at [s*DATA_W +: DATA_W]
key  out  3  per-slot flag: last returned word == KEY_COLOR

Behaviour:
- Reset: Clk is the only clock. Reset is synchronous, active-low: sampled 0 at a rising edge resets.
- During reset: ack=0, valid=0, rgb=0, key=0, rom_rd=0, rom_addr=0, RR pointer=0, tag pipeline cleared.
- In-flight reads at reset are discarded; no valid pulse follows for them.
- Eligibility: at each edge, slot s is eligible iff req[s]=1 and ack[s]=0 (current-cycle ack masks that slot). This prevents double grant.
- A requester may change addr or drop req on the edge where its ack is high.
- Winner: first eligible slot scanning ptr, ptr+1, ptr+2 (mod 3).
- If a winner exists, next cycle: ack[w]=1, rom_rd=1, rom_addr=addr[w] (captured at the sampling edge). ptr <= (w+1) mod 3.
- If no winner: ack=0, rom_rd=0, rom_addr holds, ptr holds.
- line_start: ptr <= 0 at that edge. Overrides the winner update; a grant on the same edge still issues, computed with the old ptr.
- Tag pipeline: ROM_LAT+1 entries of {live, slot[1:0]}; shifts every cycle. Entry loads {rom_rd, winner} with rom_rd.
- Return: rom_rd high in cycle c means rom_q is sampled at the end of cycle c+ROM_LAT.
- In cycle c+ROM_LAT+1: valid[slot]=1, rgb[slot]=sampled word, key[slot]=(word==KEY_COLOR).
- Other slots' rgb/key hold. valid is one-hot or zero.
- Latency: req sampled at end of cycle 0, arbiter idle → ack/rom_rd in cycle 1, valid in cycle ROM_LAT+2 (cycle 4 at default).
- Throughput: one ROM read per cycle max. A lone continuously-requesting slot gets a grant every other cycle.
- With ≥2 slots requesting, rom_rd stays high continuously and each slot gets ≥1 grant per 3 cycles (no starvation).
- Outstanding reads per slot are unlimited. Returns for a slot arrive in issue order.
- Width rules: addr/rgb are slices of flat vectors, no arithmetic on them. ptr is a 2-bit modulo-3 counter; value 3 is unreachable and is treated as 0 if reached.

Test Plan:
- Reset: Reset=0 for 3 cycles with req=3'b111 → all outputs 0 throughout. First grant after release is ack=3'b001 with rom_rd=1.
- Single request: req=3'b010, brick addr=19'h00123, ROM model returns 24'h00A0F0 → cycle 1 ack=3'b010, rom_addr=19'h00123; cycle 4 valid=3'b010, rgb slot1=24'h00A0F0, key[1]=0; slots 0/2 unchanged.
- Full contention: req=3'b111 held, distinct addresses → ack sequence 001,010,100,001,…; rom_rd high every cycle; valid sequence identical, delayed 3 cycles.
- Key detection: ROM returns 24'hFE06FF for a bg read → valid[2]=1 with key[2]=1. A following read returning 24'h101010 → key[2]=0.
- line_start coincident with the edge granting BRICK, req=3'b111 held → BRICK ack issues, next ack is 3'b001 (not 3'b100).
- Reset mid-flight: assert Reset=0 in the cycle after rom_rd=1 → no valid pulse in the next ROM_LAT+2 cycles; rgb=0.

Source files
------------

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM among the mario, brick and bg fetchers.
// A tag pipeline steers each ROM return to its slot and flags words that match the transparency key.
module sprite_fetch_arbiter #(
  parameter int unsigned       ADDR_W    = 19,
  parameter int unsigned       DATA_W    = 24,
  parameter int unsigned       ROM_LAT   = 2,
  parameter logic [DATA_W-1:0] KEY_COLOR = DATA_W'(24'hFE06FF)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  line_start,
  input  logic [2:0]            req,
  input  logic [3*ADDR_W-1:0]   addr,
  output logic [2:0]            ack,
  output logic                  rom_rd,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_q,
  output logic [2:0]            valid,
  output logic [3*DATA_W-1:0]   rgb,
  output logic [2:0]            key
);

  localparam int unsigned NSLOT = 3;

  typedef struct packed {
    logic       live;
    logic [1:0] slot;
  } tag_t;

  logic [1:0]        ptr;
  logic [1:0]        ptr_cur;
  logic [1:0]        ptr_next;
  logic [1:0]        scan;
  logic [1:0]        grant_slot;
  logic              grant_any;
  logic [NSLOT-1:0]  elig;
  logic [NSLOT-1:0]  grant_oh;
  logic [NSLOT-1:0]  ret_oh;
  logic [ADDR_W-1:0] grant_addr;
  tag_t [ROM_LAT:0]  tag;
  tag_t              tag_out;

  function automatic logic [1:0] inc_mod3(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Winner search: first eligible slot from ptr; a slot acked this cycle is masked.
  always_comb begin
    ptr_cur    = (ptr == 2'd3) ? 2'd0 : ptr;
    elig       = req & ~ack;
    grant_any  = 1'b0;
    grant_slot = 2'd0;
    scan       = ptr_cur;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      if (!grant_any && elig[scan]) begin
        grant_any  = 1'b1;
        grant_slot = scan;
      end
      scan = inc_mod3(scan);
    end
  end

  always_comb begin
    grant_oh   = '0;
    grant_addr = '0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (grant_any && grant_slot == 2'(s)) begin
        grant_oh[s] = 1'b1;
        grant_addr  = addr[s*ADDR_W +: ADDR_W];
      end
    end
  end

  // line_start restarts the rotation at mario, overriding the post-grant advance.
  always_comb begin
    ptr_next = ptr_cur;
    if (grant_any) begin
      ptr_next = inc_mod3(grant_slot);
    end
    if (line_start) begin
      ptr_next = 2'd0;
    end
  end

  always_comb begin
    tag_out = tag[ROM_LAT];
    ret_oh  = '0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (tag_out.live && tag_out.slot == 2'(s)) begin
        ret_oh[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ack      <= '0;
      rom_rd   <= 1'b0;
      rom_addr <= '0;
      ptr      <= 2'd0;
      tag      <= '0;
      valid    <= '0;
      rgb      <= '0;
      key      <= '0;
    end else begin
      ack    <= grant_oh;
      rom_rd <= grant_any;
      ptr    <= ptr_next;
      if (grant_any) begin
        rom_addr <= grant_addr;
      end
      // tag[0] pairs with rom_rd; tag[ROM_LAT] marks the cycle rom_q holds that read's word
      tag   <= {tag[ROM_LAT-1:0], tag_t'{live: grant_any, slot: grant_slot}};
      valid <= ret_oh;
      for (int unsigned s = 0; s < NSLOT; s++) begin
        if (ret_oh[s]) begin
          rgb[s*DATA_W +: DATA_W] <= rom_q;
          key[s]                  <= (rom_q == KEY_COLOR);
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Bench for sprite_fetch_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model and a latency-accurate ROM model.
`timescale 1ns/1ps
module tb_sprite_fetch_arbiter;

  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned DATA_W  = 24;
  localparam int unsigned ROM_LAT = 2;
  localparam logic [DATA_W-1:0] KEY = 24'hFE06FF;

  logic                Clk = 1'b0;
  logic                Reset = 1'b0;
  logic                line_start = 1'b0;
  logic [2:0]          req = 3'b000;
  logic [3*ADDR_W-1:0] addr = '0;
  logic [2:0]          ack;
  logic                rom_rd;
  logic [ADDR_W-1:0]   rom_addr;
  logic [DATA_W-1:0]   rom_q;
  logic [2:0]          valid;
  logic [3*DATA_W-1:0] rgb;
  logic [2:0]          key;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  sprite_fetch_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .KEY_COLOR(KEY)
  ) dut (
    .Clk(Clk), .Reset(Reset), .line_start(line_start), .req(req), .addr(addr),
    .ack(ack), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_q(rom_q),
    .valid(valid), .rgb(rgb), .key(key)
  );

  // ROM contents: explicit overrides, else a hash; addresses ending in F hold the key colour.
  logic [DATA_W-1:0] rom_mem [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    if (rom_mem.exists(a)) return rom_mem[a];
    if (a[3:0] == 4'hF) return KEY;
    return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hA5, 5'd0, a[18:16]};
  endfunction

  // ROM with ROM_LAT cycles of latency; garbage when not reading.
  logic [DATA_W-1:0] rp [ROM_LAT];
  always @(posedge Clk) begin
    for (int i = ROM_LAT - 1; i > 0; i--) rp[i] <= rp[i-1];
    rp[0] <= (rom_rd === 1'b1) ? rom_fn(rom_addr) : DATA_W'($urandom);
  end
  assign rom_q = rp[ROM_LAT-1];

  // Reference model: integer pointer, scan loop, and a queue of pending returns with due cycles.
  typedef struct {
    int                cyc_due;
    int                slot;
    logic [DATA_W-1:0] word;
  } ret_t;

  int                cyc = 0;
  int                m_ptr = 0;
  logic [2:0]        m_ack = '0;
  logic              m_rd = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [2:0]        m_valid = '0;
  logic [2:0]        m_key = '0;
  logic [DATA_W-1:0] m_rgb [3] = '{default: '0};
  ret_t              pend [$];

  always @(posedge Clk) begin : model
    logic [2:0] elig;
    int w;
    ret_t r;
    cyc++;
    if (!Reset) begin
      m_ptr = 0; m_ack = '0; m_rd = 1'b0; m_addr = '0; m_valid = '0; m_key = '0;
      for (int s = 0; s < 3; s++) m_rgb[s] = '0;
      pend.delete();
    end else begin
      m_valid = '0;
      if (pend.size() > 0 && pend[0].cyc_due == cyc) begin
        r = pend.pop_front();
        m_valid[r.slot] = 1'b1;
        m_rgb[r.slot]   = r.word;
        m_key[r.slot]   = (r.word == KEY);
      end
      elig = req & ~m_ack;
      w = -1;
      for (int k = 0; k < 3; k++)
        if (w < 0 && elig[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
      m_ack = '0;
      m_rd  = 1'b0;
      if (w >= 0) begin
        m_ack[w]  = 1'b1;
        m_rd      = 1'b1;
        m_addr    = addr[w*ADDR_W +: ADDR_W];
        m_ptr     = (w + 1) % 3;
        r.cyc_due = cyc + ROM_LAT + 1;
        r.slot    = w;
        r.word    = rom_fn(m_addr);
        pend.push_back(r);
      end
      if (line_start) m_ptr = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      req = req & ~m_ack;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    req   = 3'b111;
    addr  = {19'h00003, 19'h00002, 19'h00001};
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      n_tests++;
      if ({ack, valid, key, rom_rd} !== 10'b0 || rgb !== '0 || rom_addr !== '0) begin
        n_fail++;
        $display("FAIL reset_state cyc%0d: ack=%b valid=%b key=%b rd=%b addr=%h rgb=%h, want all zero",
                 i, ack, valid, key, rom_rd, rom_addr, rgb);
      end
    end
    Reset = 1'b1;
    @(negedge Clk);
    n_tests++;
    if (ack !== 3'b001 || rom_rd !== 1'b1 || rom_addr !== 19'h00001) begin
      n_fail++;
      $display("FAIL first_grant: ack=%b rd=%b addr=%h, want 001 1 00001", ack, rom_rd, rom_addr);
    end
    req = 3'b000;
    idle(3);
    n_tests++;
    if (valid !== 3'b001 || rgb[0 +: DATA_W] !== rom_fn(19'h00001)) begin
      n_fail++;
      $display("FAIL first_return: valid=%b rgb0=%h, want 001 %h", valid, rgb[0 +: DATA_W], rom_fn(19'h00001));
    end
    idle(2);
  endtask

  task automatic test_single();
    rom_mem[19'h00123] = 24'h00A0F0;
    req = 3'b010;
    addr[ADDR_W +: ADDR_W] = 19'h00123;
    @(negedge Clk);
    n_tests++;
    if (ack !== 3'b010 || rom_rd !== 1'b1 || rom_addr !== 19'h00123) begin
      n_fail++;
      $display("FAIL single_grant: ack=%b rd=%b addr=%h, want 010 1 00123", ack, rom_rd, rom_addr);
    end
    req = 3'b000;
    for (int c = 2; c <= 3; c++) begin
      @(negedge Clk);
      n_tests++;
      if (valid !== 3'b000) begin
        n_fail++;
        $display("FAIL single_early_valid cyc%0d: valid=%b, want 000", c, valid);
      end
    end
    @(negedge Clk);
    n_tests++;
    if (valid !== 3'b010 || rgb[DATA_W +: DATA_W] !== 24'h00A0F0 || key[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_return: valid=%b rgb1=%h key1=%b, want 010 00a0f0 0",
               valid, rgb[DATA_W +: DATA_W], key[1]);
    end
    n_tests++;
    if (rgb[0 +: DATA_W] !== rom_fn(19'h00001) || rgb[2*DATA_W +: DATA_W] !== 24'h0) begin
      n_fail++;
      $display("FAIL single_others: rgb0=%h rgb2=%h, want %h 000000",
               rgb[0 +: DATA_W], rgb[2*DATA_W +: DATA_W], rom_fn(19'h00001));
    end
    idle(2);
  endtask

  task automatic test_contention();
    logic [2:0]        seq [3];
    logic [ADDR_W-1:0] a [3];
    int                s;
    seq = '{3'b001, 3'b010, 3'b100};
    a   = '{19'h00100, 19'h00211, 19'h00322};
    line_start = 1'b1;
    @(negedge Clk);
    line_start = 1'b0;
    addr = {a[2], a[1], a[0]};
    req  = 3'b111;
    for (int i = 1; i <= 9; i++) begin
      @(negedge Clk);
      if (i <= 6) begin
        n_tests++;
        if (ack !== seq[(i-1) % 3] || rom_rd !== 1'b1) begin
          n_fail++;
          $display("FAIL contention_ack cyc%0d: ack=%b rd=%b, want %b 1", i, ack, rom_rd, seq[(i-1) % 3]);
        end
      end else begin
        n_tests++;
        if (ack !== 3'b000 || rom_rd !== 1'b0) begin
          n_fail++;
          $display("FAIL contention_idle cyc%0d: ack=%b rd=%b, want 000 0", i, ack, rom_rd);
        end
      end
      if (i >= 4) begin
        s = (i - 4) % 3;
        n_tests++;
        if (valid !== seq[s] || rgb[s*DATA_W +: DATA_W] !== rom_fn(a[s])) begin
          n_fail++;
          $display("FAIL contention_valid cyc%0d: valid=%b rgb%0d=%h, want %b %h",
                   i, valid, s, rgb[s*DATA_W +: DATA_W], seq[s], rom_fn(a[s]));
        end
      end
      if (i >= 4 && i <= 6) req = req & ~seq[(i-1) % 3];
    end
    idle(1);
  endtask

  task automatic test_key();
    rom_mem[19'h40000] = KEY;
    rom_mem[19'h40001] = 24'h101010;
    req = 3'b100;
    addr[2*ADDR_W +: ADDR_W] = 19'h40000;
    @(negedge Clk);
    addr[2*ADDR_W +: ADDR_W] = 19'h40001;
    @(negedge Clk);
    n_tests++;
    if (ack !== 3'b000) begin
      n_fail++;
      $display("FAIL lone_gap: ack=%b, want 000", ack);
    end
    @(negedge Clk);
    n_tests++;
    if (ack !== 3'b100 || rom_addr !== 19'h40001) begin
      n_fail++;
      $display("FAIL lone_regrant: ack=%b addr=%h, want 100 40001", ack, rom_addr);
    end
    req = 3'b000;
    @(negedge Clk);
    n_tests++;
    if (valid !== 3'b100 || key[2] !== 1'b1 || rgb[2*DATA_W +: DATA_W] !== KEY) begin
      n_fail++;
      $display("FAIL key_hit: valid=%b key2=%b rgb2=%h, want 100 1 fe06ff", valid, key[2], rgb[2*DATA_W +: DATA_W]);
    end
    @(negedge Clk);
    n_tests++;
    if (valid !== 3'b000 || key[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL key_hold: valid=%b key2=%b, want 000 1", valid, key[2]);
    end
    @(negedge Clk);
    n_tests++;
    if (valid !== 3'b100 || key[2] !== 1'b0 || rgb[2*DATA_W +: DATA_W] !== 24'h101010) begin
      n_fail++;
      $display("FAIL key_miss: valid=%b key2=%b rgb2=%h, want 100 0 101010", valid, key[2], rgb[2*DATA_W +: DATA_W]);
    end
    idle(2);
  endtask

  task automatic test_line_start();
    line_start = 1'b1;
    @(negedge Clk);
    line_start = 1'b0;
    req = 3'b111;
    @(negedge Clk);
    n_tests++;
    if (ack !== 3'b001) begin
      n_fail++;
      $display("FAIL ls_first: ack=%b, want 001", ack);
    end
    line_start = 1'b1;
    @(negedge Clk);
    line_start = 1'b0;
    n_tests++;
    if (ack !== 3'b010) begin
      n_fail++;
      $display("FAIL ls_brick: ack=%b, want 010", ack);
    end
    @(negedge Clk);
    n_tests++;
    if (ack !== 3'b001) begin
      n_fail++;
      $display("FAIL ls_restart: ack=%b, want 001", ack);
    end
    req = req & ~m_ack;
    drain();
  endtask

  task automatic test_reset_midflight();
    req = 3'b001;
    addr[0 +: ADDR_W] = 19'h00007;
    @(negedge Clk);
    n_tests++;
    if (rom_rd !== 1'b1 || ack !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_grant: rd=%b ack=%b, want 1 001", rom_rd, ack);
    end
    req = 3'b000;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    for (int c = 0; c < ROM_LAT + 2; c++) begin
      n_tests++;
      if (valid !== 3'b000 || rgb !== '0 || key !== 3'b000) begin
        n_fail++;
        $display("FAIL mid_discard cyc%0d: valid=%b rgb=%h key=%b, want 0", c, valid, rgb, key);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_random();
    int dens;
    for (int i = 0; i < 600; i++) begin
      @(negedge Clk);
      n_tests++;
      if ({ack, rom_rd, valid, key} !== {m_ack, m_rd, m_valid, m_key}) begin
        n_fail++;
        $display("FAIL rand_ctl cyc%0d: ack=%b rd=%b valid=%b key=%b, want %b %b %b %b",
                 i, ack, rom_rd, valid, key, m_ack, m_rd, m_valid, m_key);
      end
      n_tests++;
      if (rom_addr !== m_addr) begin
        n_fail++;
        $display("FAIL rand_addr cyc%0d: rom_addr=%h, want %h", i, rom_addr, m_addr);
      end
      n_tests++;
      if (rgb !== {m_rgb[2], m_rgb[1], m_rgb[0]}) begin
        n_fail++;
        $display("FAIL rand_rgb cyc%0d: rgb=%h, want %h", i, rgb, {m_rgb[2], m_rgb[1], m_rgb[0]});
      end
      dens       = (i < 300) ? 35 : 90;
      Reset      = ($urandom_range(0, 149) != 0);
      line_start = ($urandom_range(0, 19) == 0);
      for (int s = 0; s < 3; s++) begin
        if (m_ack[s] || !req[s]) begin
          req[s] = ($urandom_range(0, 99) < dens);
          addr[s*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        end
      end
    end
    Reset = 1'b1;
    line_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_key();
    test_line_start();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
